branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 84 ++++++++
 tb/tb_branch_predict_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters, registered decode-stage prediction,
// saturating mispredict counter. Define BPU_GSHARE_EN to XOR a global history register into the index.
module branch_predict_unit #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  output logic             predictD,
  output logic [IDX_W-1:0] idxD,
  input  logic             update_en,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  input  logic             update_pred,
  output logic             predict_wrong,
  output logic [31:0]      miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  ctr_t             pht [ENTRIES];
  logic [IDX_W-1:0] lookupIdx;
  logic [31:0]      missCnt;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign lookupIdx = pcF[IDX_W+1:2] ^ IDX_W'(ghr);

  // Shift left, newest outcome enters at bit 0; the cast keeps the low GHR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ghr <= '0;
    else if (update_en) ghr <= GHR_W'({ghr, update_taken});
  end
`else
  assign lookupIdx = pcF[IDX_W+1:2];
`endif

  assign predict_wrong = update_en & (update_pred != update_taken);
  assign miss_cnt      = missCnt;

  // NOTE: the table is flop-based so every entry can be reset to weakly not-taken; a RAM macro could not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= WEAK_NT;
    end else if (update_en) begin
      if (update_taken && pht[update_idx] != STRONG_T)
        pht[update_idx] <= ctr_t'(pht[update_idx] + 2'd1);
      else if (!update_taken && pht[update_idx] != STRONG_NT)
        pht[update_idx] <= ctr_t'(pht[update_idx] - 2'd1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Reading the table before this edge's write gives the pre-update counter; there is no bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predictD <= 1'b0;
      idxD     <= '0;
    end else if (flushD) begin
      predictD <= 1'b0;
      idxD     <= '0;
    end else if (!stallD) begin
      predictD <= pht[lookupIdx][1];
      idxD     <= lookupIdx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          missCnt <= '0;
    else if (predict_wrong && missCnt != 32'hFFFF_FFFF) missCnt <= missCnt + 32'd1;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: reference model feeds an expected-result queue
// that is popped after each clock edge. Build with +define+BPU_GSHARE_EN to cover the gshare variant.
module tb_branch_predict_unit;

  localparam int IDX_W = 6;
  localparam int GHR_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pcF;
  logic             stallD, flushD;
  logic             predictD;
  logic [IDX_W-1:0] idxD;
  logic             update_en;
  logic [IDX_W-1:0] update_idx;
  logic             update_taken, update_pred;
  logic             predict_wrong;
  logic [31:0]      miss_cnt;

  branch_predict_unit #(.IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .predictD(predictD), .idxD(idxD), .update_en(update_en), .update_idx(update_idx),
    .update_taken(update_taken), .update_pred(update_pred),
    .predict_wrong(predict_wrong), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [1:0]       mdlPht [1 << IDX_W];
  logic [GHR_W-1:0] mdlGhr;
  logic [31:0]      mdlMiss;
  logic             mdlPredD;
  logic [IDX_W-1:0] mdlIdxD;

  typedef struct packed {
    logic             pred;
    logic [IDX_W-1:0] idx;
    logic [31:0]      miss;
  } exp_t;

  exp_t expQ[$];

  task automatic modelReset();
    for (int i = 0; i < (1 << IDX_W); i++) mdlPht[i] = 2'b01;
    mdlGhr   = '0;
    mdlMiss  = '0;
    mdlPredD = 1'b0;
    mdlIdxD  = '0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic st, input logic fl,
                       input logic ue, input logic [IDX_W-1:0] ui, input logic ut, input logic up);
    pcF = pc; stallD = st; flushD = fl;
    update_en = ue; update_idx = ui; update_taken = ut; update_pred = up;
  endtask

  // Called at a falling edge with inputs applied; predicts, clocks once, then compares.
  task automatic step(input string tag);
    logic [IDX_W-1:0] li;
    exp_t             e;
    li = pcF[IDX_W+1:2];
`ifdef BPU_GSHARE_EN
    li = li ^ IDX_W'(mdlGhr);
`endif
    #1;
    check({tag, "/predict_wrong"}, predict_wrong, update_en && (update_pred != update_taken));
    if (flushD) begin
      mdlPredD = 1'b0;
      mdlIdxD  = '0;
    end else if (!stallD) begin
      mdlPredD = mdlPht[li][1];
      mdlIdxD  = li;
    end
    if (update_en) begin
      if (update_taken && mdlPht[update_idx] != 2'b11)       mdlPht[update_idx] = mdlPht[update_idx] + 2'd1;
      else if (!update_taken && mdlPht[update_idx] != 2'b00) mdlPht[update_idx] = mdlPht[update_idx] - 2'd1;
      mdlGhr = GHR_W'({mdlGhr, update_taken});
      if (update_pred != update_taken && mdlMiss != 32'hFFFF_FFFF) mdlMiss = mdlMiss + 32'd1;
    end
    e.pred = mdlPredD;
    e.idx  = mdlIdxD;
    e.miss = mdlMiss;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    check({tag, "/predictD"}, predictD, e.pred);
    check({tag, "/idxD"},     idxD,     e.idx);
    check({tag, "/miss_cnt"}, miss_cnt, e.miss);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 0, 0, 0, '0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset/predictD", predictD, 1'b0);
    check("reset/idxD",     idxD,     '0);
    check("reset/miss_cnt", miss_cnt, 32'd0);

    // First lookup after reset
    drive(32'h0040_0000, 0, 0, 0, '0, 0, 0);
    step("first_lookup");
    check("first_lookup/predictD_const", predictD, 1'b0);
    check("first_lookup/idxD_const",     idxD,     '0);

    // Train idx 5 to strongly taken (third update saturates)
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 0, 0, 1, 6'd5, 1, 1);
      step("train5");
    end
    drive(32'h0000_0014, 0, 0, 0, '0, 0, 0);
    step("lookup_trained");
`ifndef BPU_GSHARE_EN
    check("lookup_trained/predictD_const", predictD, 1'b1);
    check("lookup_trained/idxD_const",     idxD,     6'd5);
`endif

    // Stall holds, flush beats stall
    drive(32'h0000_0040, 1, 0, 0, '0, 0, 0);
    step("stall_hold");
    drive(32'h0000_0040, 1, 1, 0, '0, 0, 0);
    step("flush_over_stall");
    check("flush_over_stall/predictD_const", predictD, 1'b0);
    check("flush_over_stall/idxD_const",     idxD,     '0);

    // Mispredict: counter 11->10, miss_cnt 0->1
    drive(32'h0, 0, 0, 1, 6'd5, 0, 1);
    step("mispredict");
    check("mispredict/miss_cnt_const", miss_cnt, 32'd1);
    drive(32'h0, 0, 0, 1, 6'd5, 0, 1);
    step("decrement5");

    // Same-cycle update and lookup of idx 5 (counter 01): pre-update value wins
    drive(32'h0000_0014, 0, 0, 1, 6'd5, 1, 0);
    step("no_bypass");
    drive(32'h0000_0014, 0, 0, 0, '0, 0, 0);
    step("after_update");
`ifndef BPU_GSHARE_EN
    check("after_update/predictD_const", predictD, 1'b1);
`endif

    // Saturation of miss_cnt at all-ones
    force dut.missCnt = 32'hFFFF_FFFF;
    #1 release dut.missCnt;
    mdlMiss = 32'hFFFF_FFFF;
    drive(32'h0, 0, 0, 1, 6'd9, 1, 0);
    step("miss_saturate");
    check("miss_saturate/miss_cnt_const", miss_cnt, 32'hFFFF_FFFF);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive($urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), IDX_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step("random");
    end

    // Mid-operation asynchronous reset; an update during reset is dropped
    drive(32'h0000_0014, 0, 0, 1, 6'd5, 1, 0);
    rst = 1'b1;
    #1;
    check("async_rst/predictD", predictD, 1'b0);
    check("async_rst/idxD",     idxD,     '0);
    check("async_rst/miss_cnt", miss_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    drive(32'h0000_0014, 0, 0, 0, '0, 0, 0);
    step("post_rst_lookup");
    check("post_rst_lookup/predictD_const", predictD, 1'b0);

`ifdef BPU_GSHARE_EN
    // Two taken updates -> history 000011, lookup of 0x14 indexes 5^3 = 6
    for (int i = 0; i < 2; i++) begin
      drive(32'h0, 0, 0, 1, 6'd0, 1, 1);
      step("ghr_train");
    end
    check("ghr_value", dut.ghr, 6'b000011);
    drive(32'h0000_0014, 0, 0, 0, '0, 0, 0);
    step("gshare_lookup");
    check("gshare_lookup/idxD_const", idxD, 6'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
